uart_rx_param: RTL and testbench
================================

# uart_rx_param

Parametrised UART receiver for the MIPS I/O subsystem and successor to the fixed 8-bit, even-parity receiver. Data width, parity mode, stop-bit count, bit period and receive-buffer depth are all set by parameters. Each bit is decided by a 3-sample majority vote, and false start bits are rejected. Received words go into a first-word-fall-through FIFO with per-word parity and framing flags, and a sticky overrun flag is raised when a word is dropped.

## Interface
- CLK_PER_BIT, 5208: clk cycles per bit (50 MHz / 9600 Bd); minimum 8.
- DATA_BITS, 8: data bits per frame, 5..9.
- PARITY, 1: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: receive FIFO entries; power of 2, at least 2.

- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial line, idle high.
- rd_en  in  1  pop the FIFO head; ignored when empty.
- ovr_clr  in  1  clears overrun.
- rd_data  out  DATA_BITS  FIFO head data.
- rd_parity_err  out  1  parity error flag of the FIFO head; always 0 when PARITY = 0.
- rd_frame_err  out  1  framing error flag of the FIFO head.
- empty  out  1  FIFO empty.
- full  out  1  FIFO full.
- overrun  out  1  sticky; set when a word is dropped.
- busy  out  1  high while FSM state is not IDLE.

## Operation
- **Input synchroniser:** rx passes through 2 flops; both reset to 1. All logic below uses the synchronised value rxs.
- **Bit timer:** counts 0..CLK_PER_BIT-1, with H = CLK_PER_BIT/2 (integer division).
- **Majority vote:** samples are taken at counts H-1, H and H+1. The bit value is the majority of the 3 samples and is decided at count H+1.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on rxs = 0; the timer clears to 0.
  - START: a majority of 1 is a false start; the FSM returns to IDLE, with no push and no flag.
  - START, majority 0: at count CLK_PER_BIT-1 go to DATA.
  - DATA: DATA_BITS bits, LSB first, shifted into the data register.
  - DATA -> PARITY when PARITY != 0, else DATA -> STOP.
  - PARITY: the error flag is the XOR of the data bits and the received parity bit, XORed again with (PARITY == 2).
  - STOP: STOP_BITS bits; any stop bit voted 0 sets frame_err.
  - At the decision (count H+1) of the last stop bit, push {data, parity_err, frame_err} and go to IDLE immediately. The FSM does not wait out the rest of the stop bit, so it can resync on the next start edge.
- **FIFO push:** when the FIFO is not full, the word is written.
- **Full FIFO:** the word is dropped and overrun is set, unless rd_en is high in the same cycle. In that case the pop and the push both happen, no word is dropped, and overrun is not set.
- **Push into an empty FIFO:** the word is visible on rd_data the next cycle.
- **Pop (rd_en with FIFO not empty):** advances the head at the clock edge.
- **Counts and wrap:** pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. The occupancy counter is log2(FIFO_DEPTH)+1 bits wide.
- **overrun:** stays at 1 until ovr_clr is asserted.
  - If ovr_clr and a new drop occur in the same cycle, overrun stays at 1 (set wins).
- **Reset (including mid-frame):**
  - FSM returns to IDLE; the partial frame is discarded.
  - FIFO is emptied; overrun clears.
  - Synchronisers are set to 1; a low rx after reset is treated as a new start edge.

## Timing
- **Reset values:**
  - empty = 1, full = 0, overrun = 0, busy = 0.
  - rd_data = 0, rd_parity_err = 0, rd_frame_err = 0.
- **Input latency:** a change on the rx pin reaches rxs 2 cycles later.
- **FSM entry:** busy rises the cycle after rxs first reads 0.
- **Push latency:** the push happens on the clock edge after the last stop-bit decision, and empty falls on that same edge.
  - With 1 stop bit, the frame completes at (1 + DATA_BITS + P + STOP_BITS - 1) x CLK_PER_BIT + H + 2 cycles after the start edge reaches rxs, where P = 1 if parity is enabled, else 0.
- **Flag timing:** full, empty and overrun are registered and update on the same edge as the FIFO change that causes them.
- **Back-to-back frames:** frames with zero idle time between them are received without loss.

## Test plan
Bench settings: CLK_PER_BIT = 16, DATA_BITS = 8, PARITY = 1, STOP_BITS = 1, FIFO_DEPTH = 4.

1. Frame 0xA5 with parity bit 0 and stop bit 1 -> rd_data = 0xA5, both error flags 0, empty falls once, busy returns to 0.
2. Frame 0x3C sent with parity bit 1 -> rd_data = 0x3C, rd_parity_err = 1. Frame 0x81 with stop bit 0 -> rd_frame_err = 1.
3. rx low pulse of 6 cycles (shorter than H) -> no push, busy drops, empty stays 1. A single 1-cycle glitch inside a data bit does not change the decoded byte.
4. Five back-to-back frames 0x01..0x05 with no reads -> FIFO holds 0x01..0x04, full = 1, overrun = 1. ovr_clr then clears overrun, and popping 4 times yields 0x01, 0x02, 0x03, 0x04 in order.
5. FIFO full, with rd_en asserted on the push cycle of a 6th frame -> no overrun, and the new word ends up last in the FIFO.
6. rst asserted mid-DATA of frame 0x55, then a clean 0x66 sent -> only 0x66 is received, and all outputs are at reset values for the cycle following rst.

Source files
------------

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 3-sample majority vote per bit, false-start rejection,
// first-word-fall-through receive FIFO with per-word parity/framing flags and sticky overrun.
module uart_rx_param #(
  parameter int unsigned CLK_PER_BIT = 5208,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY      = 1,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 rd_en,
  input  logic                 ovr_clr,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_parity_err,
  output logic                 rd_frame_err,
  output logic                 empty,
  output logic                 full,
  output logic                 overrun,
  output logic                 busy
);
  localparam int unsigned H  = CLK_PER_BIT / 2;
  localparam int unsigned CW = $clog2(CLK_PER_BIT);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned WW = DATA_BITS + 2;

  localparam logic [CW-1:0] CNT_S0    = CW'(H - 1);
  localparam logic [CW-1:0] CNT_S1    = CW'(H);
  localparam logic [CW-1:0] CNT_DEC   = CW'(H + 1);
  localparam logic [CW-1:0] CNT_END   = CW'(CLK_PER_BIT - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY == 2);
  localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state_q, state_d;
  logic                 sync1, rxs;
  logic [CW-1:0]        cnt;
  logic [3:0]           bit_idx;
  logic [1:0]           samp;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err, frm_err;
  logic                 vote, decide, bit_end, push;

  logic [WW-1:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic [WW-1:0]        word, head;
  logic                 do_push, do_pop, drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rx;
      rxs   <= sync1;
    end
  end

  // Third sample is the live rxs at the decision count.
  assign vote    = (samp[0] & samp[1]) | (samp[0] & rxs) | (samp[1] & rxs);
  assign decide  = (cnt == CNT_DEC);
  assign bit_end = (cnt == CNT_END);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      S_IDLE:   if (!rxs) state_d = S_START;
      S_START: begin
        if (decide && vote) state_d = S_IDLE;
        else if (bit_end)   state_d = S_DATA;
      end
      S_DATA:   if (bit_end && bit_idx == LAST_DATA) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end) state_d = S_STOP;
      S_STOP: begin
        if (decide && bit_idx == LAST_STOP) begin
          state_d = S_IDLE;
          push    = 1'b1;
        end
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      samp    <= '1;
      shreg   <= '0;
      par_err <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      if (state_q == S_IDLE || bit_end) cnt <= '0;
      else                              cnt <= cnt + CW'(1);

      if (state_d != state_q) bit_idx <= '0;
      else if (bit_end)       bit_idx <= bit_idx + 4'd1;

      if (cnt == CNT_S0) samp[0] <= rxs;
      if (cnt == CNT_S1) samp[1] <= rxs;

      if (state_q == S_IDLE) begin
        par_err <= 1'b0;
        frm_err <= 1'b0;
      end
      if (state_q == S_DATA && decide)   shreg   <= {vote, shreg[DATA_BITS-1:1]};
      if (state_q == S_PARITY && decide) par_err <= (^shreg) ^ vote ^ ODD;
      if (state_q == S_STOP && decide && !vote) frm_err <= 1'b1;
    end
  end

  assign busy = (state_q != S_IDLE);

  // Last stop bit's vote is folded in directly since the word is pushed on its decision edge.
  assign word    = {shreg, par_err, frm_err | ~vote};
  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign do_pop  = rd_en & ~empty;
  assign do_push = push & (~full | rd_en);
  assign drop    = push & full & ~rd_en;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
      if (drop)         overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

  assign head          = empty ? '0 : mem[rd_ptr];
  assign rd_data       = head[WW-1:2];
  assign rd_parity_err = head[1];
  assign rd_frame_err  = head[0];

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: table of single frames plus hand-written
// sequences for latency, false start, overrun, read-on-push and mid-frame reset.
module tb_uart_rx_param;
  localparam int unsigned CPB = 16;

  logic       clk = 1'b0;
  logic       rst, rx, rd_en, ovr_clr;
  logic [7:0] rd_data;
  logic       rd_parity_err, rd_frame_err, empty, full, overrun, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx_param #(
    .CLK_PER_BIT(CPB),
    .DATA_BITS  (8),
    .PARITY     (1),
    .STOP_BITS  (1),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .rd_en        (rd_en),
    .ovr_clr      (ovr_clr),
    .rd_data      (rd_data),
    .rd_parity_err(rd_parity_err),
    .rd_frame_err (rd_frame_err),
    .empty        (empty),
    .full         (full),
    .overrun      (overrun),
    .busy         (busy)
  );

  typedef struct {
    logic [7:0] data;
    logic       pbit;
    logic       sbit;
    int         glitch;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vec [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One bit period; glitch_off >= 0 inverts rx for that single cycle.
  task automatic send_bit(input logic v, input int glitch_off);
    for (int c = 0; c < int'(CPB); c++) begin
      rx = (c == glitch_off) ? ~v : v;
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int gbit);
    logic [10:0] bits;
    bits = {s, p, d, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(bits[i], (i == gbit) ? 9 : -1);
    rx = 1'b1;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = '{8'h3C, 1'b1, 1'b1, -1, 8'h3C, 1'b1, 1'b0};
    vec[1] = '{8'h81, 1'b0, 1'b0, -1, 8'h81, 1'b0, 1'b1};
    vec[2] = '{8'h5A, 1'b0, 1'b1,  4, 8'h5A, 1'b0, 1'b0};
    vec[3] = '{8'h00, 1'b0, 1'b1, -1, 8'h00, 1'b0, 1'b0};
    vec[4] = '{8'hFF, 1'b0, 1'b1,  1, 8'hFF, 1'b0, 1'b0};
    vec[5] = '{8'h7E, 1'b1, 1'b1, -1, 8'h7E, 1'b1, 1'b0};
    vec[6] = '{8'h01, 1'b1, 1'b1, -1, 8'h01, 1'b0, 1'b0};
    vec[7] = '{8'hC3, 1'b0, 1'b1, 10, 8'hC3, 1'b0, 1'b0};

    rst = 1'b1; rx = 1'b1; rd_en = 1'b0; ovr_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(rd_data), 32'd0);
    check("rst_perr", 32'(rd_parity_err), 32'd0);
    check("rst_ferr", 32'(rd_frame_err), 32'd0);
    repeat (5) @(negedge clk);

    // Frame 0xA5 with entry and push latency measured from the first rx-low edge E
    fork
      send_frame(8'hA5, 1'b0, 1'b1, -1);
      begin
        @(posedge clk); #1 check("t1_busy_before", 32'(busy), 32'd0);
        repeat (3) @(posedge clk); #1 check("t1_busy_entry", 32'(busy), 32'd1);
        repeat (168) @(posedge clk); #1 check("t1_empty_before_push", 32'(empty), 32'd1);
        @(posedge clk); #1 check("t1_empty_at_push", 32'(empty), 32'd0);
      end
    join
    repeat (40) @(negedge clk);
    check("t1_data", 32'(rd_data), 32'hA5);
    check("t1_perr", 32'(rd_parity_err), 32'd0);
    check("t1_ferr", 32'(rd_frame_err), 32'd0);
    check("t1_busy_end", 32'(busy), 32'd0);
    pop();
    check("t1_empty_after_pop", 32'(empty), 32'd1);

    for (int i = 0; i < 8; i++) begin
      send_frame(vec[i].data, vec[i].pbit, vec[i].sbit, vec[i].glitch);
      repeat (40) @(negedge clk);
      check($sformatf("v%0d_empty", i), 32'(empty), 32'd0);
      check($sformatf("v%0d_data", i), 32'(rd_data), 32'(vec[i].exp_data));
      check($sformatf("v%0d_perr", i), 32'(rd_parity_err), 32'(vec[i].exp_perr));
      check($sformatf("v%0d_ferr", i), 32'(rd_frame_err), 32'(vec[i].exp_ferr));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
      pop();
      check($sformatf("v%0d_empty_pop", i), 32'(empty), 32'd1);
    end

    // False start: 6-cycle low pulse
    rx = 1'b0;
    repeat (6) @(negedge clk);
    rx = 1'b1;
    @(posedge clk); #1 check("fs_busy_mid", 32'(busy), 32'd1);
    repeat (30) @(negedge clk);
    check("fs_busy_end", 32'(busy), 32'd0);
    check("fs_empty", 32'(empty), 32'd1);

    // Five back-to-back frames with no reads
    for (int i = 1; i <= 5; i++) send_frame(8'(i), ^(8'(i)), 1'b1, -1);
    repeat (20) @(negedge clk);
    check("ovr_full", 32'(full), 32'd1);
    check("ovr_set", 32'(overrun), 32'd1);
    check("ovr_head", 32'(rd_data), 32'h01);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    check("ovr_cleared", 32'(overrun), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("ovr_pop%0d", i), 32'(rd_data), 32'(i));
      pop();
    end
    check("ovr_empty", 32'(empty), 32'd1);
    check("ovr_not_full", 32'(full), 32'd0);

    // Full FIFO with rd_en on the push edge of a sixth frame
    for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), ^(8'h11 + 8'(i)), 1'b1, -1);
    check("rdp_full", 32'(full), 32'd1);
    check("rdp_no_ovr_before", 32'(overrun), 32'd0);
    fork
      send_frame(8'h15, 1'b1, 1'b1, -1);
      begin
        @(posedge clk);
        repeat (171) @(posedge clk);
        @(negedge clk); rd_en = 1'b1;
        @(negedge clk); rd_en = 1'b0;
      end
    join
    repeat (10) @(negedge clk);
    check("rdp_no_ovr", 32'(overrun), 32'd0);
    check("rdp_full_after", 32'(full), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rdp_pop%0d", i), 32'(rd_data), 32'(8'h12 + 8'(i)));
      pop();
    end
    check("rdp_last", 32'(rd_data), 32'h15);
    check("rdp_nonempty", 32'(empty), 32'd0);

    // Reset in the middle of DATA of 0x55 with 0x15 still in the FIFO
    send_bit(1'b0, -1);
    send_bit(1'b1, -1);
    send_bit(1'b0, -1);
    send_bit(1'b1, -1);
    send_bit(1'b0, -1);
    check("mr_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1; rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mr_empty", 32'(empty), 32'd1);
    check("mr_full", 32'(full), 32'd0);
    check("mr_overrun", 32'(overrun), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_data", 32'(rd_data), 32'd0);
    check("mr_perr", 32'(rd_parity_err), 32'd0);
    check("mr_ferr", 32'(rd_frame_err), 32'd0);
    repeat (20) @(negedge clk);
    send_frame(8'h66, 1'b0, 1'b1, -1);
    repeat (40) @(negedge clk);
    check("mr_rx_data", 32'(rd_data), 32'h66);
    check("mr_rx_perr", 32'(rd_parity_err), 32'd0);
    check("mr_rx_ferr", 32'(rd_frame_err), 32'd0);
    pop();
    check("mr_only_one", 32'(empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
